// File: rtl/seq_shift_add_mult.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around an 8-bit carry
// lookahead adder; one partial-product step per clock, valid/ready on both sides.

module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] sum,
    output logic       c8
);

    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] c_int;
    logic [1:0] grp_g;
    logic [1:0] grp_p;
    logic [1:0] grp_cin;

    assign p = a ^ b;
    assign g = a & b;

    // Two 4-bit lookahead groups; carries inside a group depend only on the group carry-in.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grp
            localparam int B = gi * 4;

            assign c_int[B]   = grp_cin[gi];
            assign c_int[B+1] = g[B] | (p[B] & grp_cin[gi]);
            assign c_int[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_cin[gi]);
            assign c_int[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                              | (p[B+2] & p[B+1] & p[B] & grp_cin[gi]);

            assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = &p[B+3:B];
        end
    endgenerate

    assign grp_cin[0] = c0;
    assign grp_cin[1] = grp_g[0] | (grp_p[0] & c0);

    assign sum = p ^ c_int;
    assign c8  = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & c0);

endmodule

module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [3:0]       count_q, count_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] add_sum;
    logic             add_c8;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    cla_8bit cla_8bit (
        .a   (acc_hi_q),
        .b   (addend),
        .c0  (1'b0),
        .sum (add_sum),
        .c8  (add_c8)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = 4'd0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Carry-out enters at the top so the full 16-bit result never overflows.
                {acc_hi_d, acc_lo_d} = {add_c8, add_sum, acc_lo_q[WIDTH-1:1]};
                count_d = count_q + 4'd1;
                if (count_q == 4'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult: expected products are queued at
// acceptance and compared by a monitor whenever a product is transferred.

module tb_seq_shift_add_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int          checks;
    int          errors;
    int          cyc;
    int          accept_cyc;
    logic [15:0] sb[$];

    seq_shift_add_mult #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every transfer pops the oldest expected product.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL xfer_unexpected product=%0d required=none", product);
            end else begin
                logic [15:0] exp_p;
                exp_p = sb.pop_front();
                if (product !== exp_p) begin
                    errors = errors + 1;
                    $display("FAIL xfer_product got=%0d required=%0d", product, exp_p);
                end else begin
                    $display("xfer product=%0d ok", product);
                end
            end
        end
    end

    // Drives one operand pair; returns one step after the acceptance edge.
    task automatic send(input logic [7:0] av, input logic [7:0] bv);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        sb.push_back(16'(av) * 16'(bv));
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // Waits for the handshake edge with optional random stalls.
    task automatic wait_xfer(input bit stall);
        bit hs;
        int n;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 300) begin
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) hs = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
        if (!hs) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL xfer_timeout out_valid=%0b required=1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'd5;
        b = 8'd5;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checks = checks + 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b required=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b required=0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b required=0", busy); end
        if (product !== 16'd0) begin errors++; $display("FAIL rst_product got=%0d required=0", product); end
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_no_capture busy=%0b required=0", busy); end
    endtask

    task automatic test_basic();
        send(8'd13, 8'd11);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            checks = checks + 1;
            if (out_valid !== (k == 8)) begin
                errors++;
                $display("FAIL basic_latency step=%0d out_valid=%0b required=%0b", k, out_valid, (k == 8));
            end
        end
        checks = checks + 2;
        if (product !== 16'h008F) begin errors++; $display("FAIL basic_product got=%0d required=143", product); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy got=%0b required=0", in_ready); end
        @(posedge clk);
        #1;
        checks = checks + 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%0b required=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_back got=%0b required=1", in_ready); end
    endtask

    task automatic test_carry_zero();
        send(8'd255, 8'd255); wait_xfer(1'b0);
        send(8'd0, 8'd200);   wait_xfer(1'b0);
        send(8'd1, 8'd200);   wait_xfer(1'b0);
        send(8'd128, 8'd2);   wait_xfer(1'b0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'd7, 8'd9);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 8'd3;
            b = 8'd3;
            @(negedge clk);
            checks = checks + 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%0b required=1", out_valid); end
            if (product !== 16'd63) begin errors++; $display("FAIL bp_product got=%0d required=63", product); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b required=0", in_ready); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_xfer(1'b0);
        checks = checks + 1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer got=%0b required=0", out_valid); end
        send(8'd3, 8'd3);
        wait_xfer(1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        send(8'd100, 8'd100);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        checks = checks + 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%0b required=1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b required=0", busy); end
        if (product !== 16'd0) begin errors++; $display("FAIL abort_product got=%0d required=0", product); end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks = checks + 1;
        if (seen) begin errors++; $display("FAIL abort_out_valid got=1 required=0"); end
        @(posedge clk);
        #1;
        send(8'd100, 8'd100);
        wait_xfer(1'b0);
    endtask

    task automatic test_random();
        int prev;
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (prev >= 0) begin
                checks = checks + 1;
                if (accept_cyc - prev < 10) begin
                    errors++;
                    $display("FAIL rand_interval got=%0d required>=10", accept_cyc - prev);
                end
            end
            prev = accept_cyc;
            wait_xfer(1'b1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        accept_cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = 8'd0;
        b = 8'd0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_carry_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
